// File: rtl/scr_stack_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scr_stack_unit_pkg
// Brief    : Shared types and default widths for the scratch/stack unit.
// Revision : 1.0  initial release
// ============================================================================
package scr_stack_unit_pkg;

    localparam int unsigned c_ADDR_W_DEF = 8;
    localparam int unsigned c_DATA_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/scr_stack_unit_ram.sv
`default_nettype none
// ============================================================================
// Module   : scr_ram
// Brief    : Single-port scratch array, synchronous write and registered read.
// Revision : 1.0  initial release
// ============================================================================
module scr_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Read register only loads on a read, so it holds between reads.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/scr_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : scr_stack_unit
// Brief    : Scratch memory with power-up clear sequence plus stack pointer.
// Revision : 1.0  initial release
// ============================================================================
module scr_stack_unit
    import scr_stack_unit_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] SCR_ADDR,
    input  logic [DATA_W-1:0] SCR_DIN,
    input  logic              SCR_REQ,
    input  logic              SCR_WE,
    input  logic              SP_LD,
    input  logic              SP_INCR,
    input  logic              SP_DECR,
    input  logic [ADDR_W-1:0] SP_DIN,
    output logic [DATA_W-1:0] SCR_DOUT,
    output logic              SCR_ACK,
    output logic              SCR_RDY,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic [ADDR_W-1:0] SP_M1,
    output logic              SP_WRAP
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] din_q,     din_d;
    logic              we_q,      we_d;
    logic              rd_seen_q, rd_seen_d;
    logic [ADDR_W-1:0] sp_q,      sp_d;
    logic              wrap_q,    wrap_d;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            rd_seen_q <= 1'b0;
            sp_q      <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            rd_seen_q <= rd_seen_d;
            sp_q      <= sp_d;
            wrap_q    <= wrap_d;
        end
    end

    // Reads sample the array at the accept edge so data is valid with ACK;
    // writes commit during ACCESS from the latched copy.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        we_d      = we_q;
        rd_seen_d = rd_seen_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = SCR_ADDR;
        ram_wdata = din_q;
        SCR_RDY   = 1'b0;
        SCR_ACK   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == c_ADDR_MAX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                SCR_RDY = 1'b1;
                if (SCR_REQ) begin
                    addr_d  = SCR_ADDR;
                    din_d   = SCR_DIN;
                    we_d    = SCR_WE;
                    ram_re  = ~SCR_WE;
                    state_d = ST_ACCESS;
                    if (!SCR_WE) begin
                        rd_seen_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                SCR_ACK  = 1'b1;
                ram_addr = addr_q;
                ram_we   = we_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        sp_d   = sp_q;
        wrap_d = wrap_q;
        if (SP_LD) begin
            sp_d   = SP_DIN;
            wrap_d = 1'b0;
        end else if (SP_INCR && !SP_DECR) begin
            sp_d = sp_q + 1'b1;
            if (sp_q == c_ADDR_MAX) begin
                wrap_d = 1'b1;
            end
        end else if (SP_DECR && !SP_INCR) begin
            sp_d = sp_q - 1'b1;
            if (sp_q == '0) begin
                wrap_d = 1'b1;
            end
        end
    end

    scr_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_scr_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Read register has no reset; mask it until the first read after reset.
    assign SCR_DOUT = rd_seen_q ? ram_rdata : '0;
    assign SP_OUT   = sp_q;
    assign SP_M1    = sp_q - 1'b1;
    assign SP_WRAP  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scr_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr_stack_unit
// Brief    : Directed self-checking bench for scr_stack_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_scr_stack_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SCR_ADDR;
    logic [9:0] SCR_DIN;
    logic       SCR_REQ;
    logic       SCR_WE;
    logic       SP_LD;
    logic       SP_INCR;
    logic       SP_DECR;
    logic [7:0] SP_DIN;
    logic [9:0] SCR_DOUT;
    logic       SCR_ACK;
    logic       SCR_RDY;
    logic [7:0] SP_OUT;
    logic [7:0] SP_M1;
    logic       SP_WRAP;

    int n_tests = 0;
    int n_fail  = 0;

    scr_stack_unit #(
        .ADDR_W (8),
        .DATA_W (10)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SCR_ADDR (SCR_ADDR),
        .SCR_DIN  (SCR_DIN),
        .SCR_REQ  (SCR_REQ),
        .SCR_WE   (SCR_WE),
        .SP_LD    (SP_LD),
        .SP_INCR  (SP_INCR),
        .SP_DECR  (SP_DECR),
        .SP_DIN   (SP_DIN),
        .SCR_DOUT (SCR_DOUT),
        .SCR_ACK  (SCR_ACK),
        .SCR_RDY  (SCR_RDY),
        .SP_OUT   (SP_OUT),
        .SP_M1    (SP_M1),
        .SP_WRAP  (SP_WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles until ready, bounded so a stuck clear cannot hang the run.
    task automatic wait_clear(input string tag, input int start);
        int n;
        n = start;
        while (!SCR_RDY && n < 300) begin
            tick();
            n++;
        end
        check(tag, n, 256);
    endtask

    // Inputs are scrambled during ACCESS; the latched copy must be used.
    task automatic access(input logic we, input logic [7:0] a, input logic [9:0] d,
                          input logic [9:0] exp_dout, input string tag);
        SCR_REQ  = 1'b1;
        SCR_WE   = we;
        SCR_ADDR = a;
        SCR_DIN  = d;
        tick();
        check({tag, "_ack"}, SCR_ACK, 1);
        check({tag, "_rdy"}, SCR_RDY, 0);
        check({tag, "_dout"}, SCR_DOUT, exp_dout);
        SCR_REQ  = 1'b0;
        SCR_WE   = ~we;
        SCR_ADDR = ~a;
        SCR_DIN  = ~d;
        tick();
        check({tag, "_ack_off"}, SCR_ACK, 0);
        check({tag, "_dout_hold"}, SCR_DOUT, exp_dout);
    endtask

    task automatic sp_op(input logic ld, input logic inc, input logic dec, input logic [7:0] din);
        SP_LD   = ld;
        SP_INCR = inc;
        SP_DECR = dec;
        SP_DIN  = din;
        tick();
        SP_LD   = 1'b0;
        SP_INCR = 1'b0;
        SP_DECR = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        SCR_ADDR = '0;
        SCR_DIN  = '0;
        SCR_REQ  = 1'b0;
        SCR_WE   = 1'b0;
        SP_LD    = 1'b0;
        SP_INCR  = 1'b0;
        SP_DECR  = 1'b0;
        SP_DIN   = '0;
        repeat (3) tick();

        check("rst_rdy",  SCR_RDY,  0);
        check("rst_ack",  SCR_ACK,  0);
        check("rst_sp",   SP_OUT,   0);
        check("rst_wrap", SP_WRAP,  0);
        check("rst_dout", SCR_DOUT, 0);
        check("rst_spm1", SP_M1,    8'hFF);

        // Release with a stack load during CLEAR; requests must be ignored.
        RST     = 1'b0;
        SP_LD   = 1'b1;
        SP_DIN  = 8'h33;
        SCR_REQ = 1'b1;
        SCR_WE  = 1'b1;
        SCR_DIN = 10'h3FF;
        tick();
        SP_LD   = 1'b0;
        SCR_REQ = 1'b0;
        SCR_WE  = 1'b0;
        check("clr_sp_ld", SP_OUT,  8'h33);
        check("clr_rdy",   SCR_RDY, 0);
        wait_clear("clr_len", 1);

        access(1'b0, 8'h00, 10'h000, 10'h000, "rd00");
        access(1'b0, 8'h7F, 10'h000, 10'h000, "rd7f");
        access(1'b0, 8'hFF, 10'h000, 10'h000, "rdff");
        access(1'b1, 8'h10, 10'h3A5, 10'h000, "wr10");
        access(1'b0, 8'h10, 10'h000, 10'h3A5, "rd10");
        access(1'b1, 8'h30, 10'h155, 10'h3A5, "wr30");
        access(1'b0, 8'h30, 10'h000, 10'h155, "rd30");
        access(1'b0, 8'hEF, 10'h000, 10'h000, "rdef");
        access(1'b0, 8'h11, 10'h000, 10'h000, "rd11");

        // Continuous request: one access every two cycles.
        SCR_REQ  = 1'b1;
        SCR_WE   = 1'b0;
        SCR_ADDR = 8'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("thru_ack%0d", i), SCR_ACK, (i % 2 == 0) ? 1 : 0);
        end
        SCR_REQ = 1'b0;
        check("thru_dout", SCR_DOUT, 10'h3A5);
        tick();

        sp_op(1'b1, 1'b0, 1'b0, 8'h00);
        check("ld0_wrap", SP_WRAP, 0);
        sp_op(1'b0, 1'b0, 1'b1, 8'h00);
        check("dec_sp",   SP_OUT,  8'hFF);
        check("dec_m1",   SP_M1,   8'hFE);
        check("dec_wrap", SP_WRAP, 1);
        sp_op(1'b0, 1'b0, 1'b1, 8'h00);
        check("dec2_sp",   SP_OUT,  8'hFE);
        check("dec2_wrap", SP_WRAP, 1);
        sp_op(1'b1, 1'b0, 1'b0, 8'h05);
        check("ld5_sp",   SP_OUT,  8'h05);
        check("ld5_wrap", SP_WRAP, 0);
        sp_op(1'b1, 1'b1, 1'b0, 8'h40);
        check("ldinc_sp", SP_OUT, 8'h40);
        sp_op(1'b0, 1'b1, 1'b1, 8'h00);
        check("incdec_sp", SP_OUT, 8'h40);
        sp_op(1'b0, 1'b1, 1'b0, 8'h00);
        check("inc_sp",   SP_OUT,  8'h41);
        check("inc_m1",   SP_M1,   8'h40);
        check("inc_wrap", SP_WRAP, 0);
        sp_op(1'b1, 1'b0, 1'b0, 8'hFF);
        sp_op(1'b0, 1'b1, 1'b0, 8'h00);
        check("incw_sp",   SP_OUT,  8'h00);
        check("incw_m1",   SP_M1,   8'hFF);
        check("incw_wrap", SP_WRAP, 1);

        // Reset mid-ACCESS of a write: clear reruns and wipes the word.
        sp_op(1'b1, 1'b0, 1'b0, 8'h12);
        SCR_REQ  = 1'b1;
        SCR_WE   = 1'b1;
        SCR_ADDR = 8'h20;
        SCR_DIN  = 10'h2AA;
        tick();
        check("abort_ack", SCR_ACK, 1);
        SCR_REQ = 1'b0;
        SCR_WE  = 1'b0;
        RST     = 1'b1;
        #1;
        check("abort_rdy",  SCR_RDY,  0);
        check("abort_ack0", SCR_ACK,  0);
        check("abort_sp",   SP_OUT,   0);
        check("abort_dout", SCR_DOUT, 0);
        repeat (2) tick();
        RST = 1'b0;
        wait_clear("clr2_len", 0);
        check("clr2_sp", SP_OUT, 0);
        access(1'b0, 8'h20, 10'h000, 10'h000, "rd20");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scr_stack_unit.md
SCR_STACK_UNIT -- requirements
Module: scr_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 8, scratch address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 10, scratch word width.
REQ-003 Port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port RST  in  1  reset, asynchronous, active-high.
REQ-005 Port SCR_ADDR  in  ADDR_W  word address from the scratch address mux.
REQ-006 Port SCR_DIN  in  DATA_W  write data.
REQ-007 Port SCR_REQ  in  1  access request, sampled when SCR_RDY=1.
REQ-008 Port SCR_WE  in  1  1=write, 0=read; qualified by SCR_REQ.
REQ-009 Port SP_LD / SP_INCR / SP_DECR  in  1 each  stack-pointer load / increment / decrement.
REQ-010 Port SP_DIN  in  ADDR_W  stack-pointer load value.
REQ-011 Port SCR_DOUT  out  DATA_W  registered read data.
REQ-012 Port SCR_ACK  out  1  one-cycle pulse: access complete.
REQ-013 Port SCR_RDY  out  1  block can accept a request.
REQ-014 Port SP_OUT  out  ADDR_W  current stack pointer (feeds mux input two).
REQ-015 Port SP_M1  out  ADDR_W  SP_OUT-1 mod 2**ADDR_W (feeds mux input three).
REQ-016 Port SP_WRAP  out  1  sticky flag: SP wrapped 0xFF->0x00 or 0x00->0xFF.

Function
REQ-017 FSM states CLEAR, IDLE, ACCESS.
REQ-018 CLEAR: writes 0 to word CLR_CNT each cycle, CLR_CNT 0..2**ADDR_W-1; at last word -> IDLE; SCR_RDY=0 throughout; requests ignored.
REQ-019 IDLE: SCR_RDY=1; SCR_REQ=1 latches address, data, WE -> ACCESS.
REQ-020 ACCESS: write commits word, or read loads SCR_DOUT from array; SCR_ACK=1 for this one cycle; -> IDLE; SCR_RDY=0.
REQ-021 Latency: request accepted cycle N -> SCR_ACK and valid SCR_DOUT cycle N+1; max throughput one access per 2 cycles.
REQ-022 SCR_DOUT holds last read value until next read completes; writes never change it.
REQ-023 Read after write to same address in consecutive accesses returns new data.
REQ-024 SP priority: SP_LD > SP_INCR > SP_DECR; INCR and DECR together (no LD) = no change.
REQ-025 SP arithmetic modulo 2**ADDR_W; wrap sets SP_WRAP; SP_WRAP cleared only by reset or SP_LD.
REQ-026 SP operations act in every state, including CLEAR, independent of the access FSM.
REQ-027 SP_M1 combinational from SP register; SP_OUT registered.
REQ-028 SCR_WE/SCR_DIN/SCR_ADDR changes while in ACCESS have no effect (latched copy used).

Reset
REQ-029 RST asserted, any state: state=CLEAR, CLR_CNT=0, SP_OUT=0, SP_WRAP=0, SCR_DOUT=0, SCR_ACK=0, SCR_RDY=0.
REQ-030 RST mid-ACCESS aborts access; pending write may or may not commit, but CLEAR then zeroes the array.
REQ-031 Array contents not reset asynchronously; zeroing only via CLEAR sequence.

Structure
REQ-032 Shared package holds state enum (CLEAR, IDLE, ACCESS) and default ADDR_W/DATA_W constants.
REQ-033 One sub-module, scr_ram: single-port sync-write/sync-read array, no reset.
REQ-034 SP register, flags, FSM in top level; no latches.

Verification
REQ-035 Reset release -> SCR_RDY low exactly 256 cycles, then high; read 0x00, 0x7F, 0xFF all return 0x000.
REQ-036 Write 0x3A5 to 0x10 then read 0x10 -> SCR_ACK one cycle after each accept, SCR_DOUT=0x3A5.
REQ-037 SP_LD 0x00 then SP_DECR -> SP_OUT=0xFF, SP_M1=0xFE, SP_WRAP=1; SP_LD 0x05 -> SP_WRAP=0.
REQ-038 SP_LD=1, SP_INCR=1, SP_DIN=0x40 -> SP_OUT=0x40; SP_INCR+SP_DECR together -> unchanged.
REQ-039 SCR_REQ held high continuously -> accepts on alternate cycles, SCR_ACK alternating 0/1.
REQ-040 RST pulsed during ACCESS after write 0x2AA to 0x20 -> CLEAR reruns, read 0x20 returns 0x000, SP_OUT=0.
